t07_esp_nibble_rx: RTL and testbench

Receiver stage between the ESP32 link and the core of `t07_top`. It synchronises the 4-bit `ESP_in` bus and a strobe, packs eight nibbles into one 32-bit word (MSB nibble first), and buffers completed words in a first-word-fall-through FIFO. The downstream consumer (the memory/CPU side of `t07_top`) pops words with a single-cycle read enable.

---
 rtl/t07_esp_nibble_rx.sv | 172 +++++++++++++++++
 tb/tb_t07_esp_nibble_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/t07_esp_nibble_rx.sv
// ESP32 nibble receiver: sync strobe/data, pack 8 nibbles MSB-first, FWFT FIFO; word visible SYNC_STAGES+1 cycles after 8th strobe.
// No backpressure to the ESP32: push into a full FIFO drops the word (sticky overflow_o); optional partial-word timeout via T07_ESP_RX_TIMEOUT_EN.
`timescale 1ns/1ps
module t07_esp_nibble_rx #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [3:0]                   ESP_in,
    input  logic                         esp_strobe_i,
    input  logic                         rd_en_i,
    output logic [31:0]                  data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0]       strb_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  data_sync_q;
    logic                         strb_dly_q;
    logic [2:0]                   nib_cnt_q, nib_cnt_d;
    // Only the seven most recent nibbles are ever needed; the eighth comes straight from the synchroniser.
    logic [27:0]                  shift_q, shift_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         ovf_q, ovf_d;
    logic [31:0]                  mem_q [DEPTH];

    logic                         strb_s;
    logic [3:0]                   nib_s;
    logic                         edge_det;
    logic                         word_done;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;
    logic                         drop;
    logic [31:0]                  word;

    assign strb_s     = strb_sync_q[SYNC_STAGES-1];
    assign nib_s      = data_sync_q[SYNC_STAGES-1];
    assign edge_det   = strb_s & ~strb_dly_q;
    assign word_done  = edge_det && (nib_cnt_q == 3'd7);
    assign word       = {shift_q, nib_s};
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop        = rd_en_i & ~fifo_empty;
    // A full FIFO still accepts a word if the head leaves in the same cycle.
    assign push       = word_done & (~fifo_full | pop);
    assign drop       = word_done & fifo_full & ~pop;

`ifdef T07_ESP_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          tmo_q, tmo_d;

    always_comb begin
        nib_cnt_d = nib_cnt_q;
        shift_d   = shift_q;
        idle_d    = '0;
        tmo_d     = 1'b0;
        if (edge_det) begin
            shift_d   = word[27:0];
            nib_cnt_d = nib_cnt_q + 3'd1;
        end else if (nib_cnt_q != 3'd0) begin
            if (idle_q == IDLE_LAST) begin
                nib_cnt_d = 3'd0;
                shift_d   = '0;
                tmo_d     = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    always_comb begin
        nib_cnt_d = nib_cnt_q;
        shift_d   = shift_q;
        if (edge_det) begin
            shift_d   = word[27:0];
            nib_cnt_d = nib_cnt_q + 3'd1;
        end
    end

    assign timeout_o = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            strb_sync_q <= '0;
            data_sync_q <= '0;
            strb_dly_q  <= 1'b0;
            nib_cnt_q   <= 3'd0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], esp_strobe_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ESP_in};
            strb_dly_q  <= strb_s;
            nib_cnt_q   <= nib_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: data_o is gated by the empty flag.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign valid_o    = ~fifo_empty;
    assign data_o     = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_t07_esp_nibble_rx.sv
// Directed bench for t07_esp_nibble_rx: table of word pushes/pops plus hand sequences for latency, full+pop, wrap, reset and timeout.
`timescale 1ns/1ps
module tb_t07_esp_nibble_rx;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  ESP_in = 4'h0;
    logic        esp_strobe_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    t07_esp_nibble_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .nrst(nrst), .ESP_in(ESP_in), .esp_strobe_i(esp_strobe_i),
        .rd_en_i(rd_en_i), .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
        .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    always #2 clk = ~clk;

    typedef struct {
        bit          snd;
        logic [31:0] word;
        bit          pop;
        logic [3:0]  exp_cnt;
        bit          exp_vld;
        logic [31:0] exp_head;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        ESP_in = n;
        @(negedge clk);
        esp_strobe_i = 1'b1;
        @(negedge clk);
        esp_strobe_i = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
    endtask

    // Eighth nibble: optionally pulse rd_en_i in the cycle the word lands, optionally check latency.
    task automatic send_last(input logic [3:0] n, input bit pop_at_push, input bit lat_chk,
                             input logic [31:0] exp_word);
        ESP_in = n;
        @(negedge clk);
        esp_strobe_i = 1'b1;
        @(negedge clk);
        esp_strobe_i = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        if (lat_chk) chk("lat_valid_early", 32'(valid_o), 32'd0);
        rd_en_i = pop_at_push;
        @(negedge clk);
        rd_en_i = 1'b0;
        if (lat_chk) begin
            chk("lat_valid", 32'(valid_o), 32'd1);
            chk("lat_data", data_o, exp_word);
            chk("lat_count", 32'(count_o), 32'd1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit pop_at_push);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 7; i++) send_nib(tmp[31-4*i -: 4]);
        send_last(tmp[3:0], pop_at_push, 1'b0, 32'h0);
    endtask

    task automatic do_pop();
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 9; i++)
            tbl[i] = '{1'b1, 32'(i + 1), 1'b0, (i < 8) ? 4'(i + 1) : 4'd8, 1'b1, 32'h1, (i == 8)};
        for (int j = 1; j <= 8; j++)
            tbl[8 + j] = '{1'b0, 32'h0, 1'b1, 4'(8 - j), (j < 8), 32'(j + 1), 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_data", data_o, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_tmo", 32'(timeout_o), 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Pop while empty has no effect.
        do_pop();
        chk("pop_empty_count", 32'(count_o), 32'd0);

        // AABBCCDD with latency check on the last nibble.
        send_nib(4'hA); send_nib(4'hA); send_nib(4'hB); send_nib(4'hB);
        send_nib(4'hC); send_nib(4'hC); send_nib(4'hD);
        send_last(4'hD, 1'b0, 1'b1, 32'hAABBCCDD);
        do_pop();
        chk("t1_pop_valid", 32'(valid_o), 32'd0);
        chk("t1_pop_count", 32'(count_o), 32'd0);

        // Fill past depth, then drain.
        for (int v = 0; v < 17; v++) begin
            if (tbl[v].snd) send_word(tbl[v].word, 1'b0);
            if (tbl[v].pop) do_pop();
            chk($sformatf("tbl%0d_count", v), 32'(count_o), 32'(tbl[v].exp_cnt));
            chk($sformatf("tbl%0d_valid", v), 32'(valid_o), 32'(tbl[v].exp_vld));
            chk($sformatf("tbl%0d_ovf", v), 32'(overflow_o), 32'(tbl[v].exp_ovf));
            if (tbl[v].exp_vld) chk($sformatf("tbl%0d_head", v), data_o, tbl[v].exp_head);
        end
        pulse_reset();
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Full FIFO, ninth word lands together with a pop.
        for (int i = 0; i < 8; i++) send_word(32'h10 + 32'(i), 1'b0);
        chk("full_count", 32'(count_o), 32'd8);
        send_word(32'h18, 1'b1);
        chk("fullpop_count", 32'(count_o), 32'd8);
        chk("fullpop_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpop_head%0d", i), data_o, 32'h11 + 32'(i));
            do_pop();
        end
        chk("fullpop_drained", 32'(valid_o), 32'd0);

        // Pointer wrap: twelve push/pop pairs.
        for (int i = 0; i < 12; i++) begin
            send_word(32'hC0DE0000 + 32'(i), 1'b0);
            chk($sformatf("wrap_head%0d", i), data_o, 32'hC0DE0000 + 32'(i));
            chk($sformatf("wrap_cnt%0d", i), 32'(count_o), 32'd1);
            do_pop();
        end
        chk("wrap_empty", 32'(count_o), 32'd0);

        // Reset mid-word discards the partial nibbles.
        send_nib(4'hE); send_nib(4'hE); send_nib(4'hE);
        pulse_reset();
        send_word(32'h12345678, 1'b0);
        chk("midrst_data", data_o, 32'h12345678);
        chk("midrst_count", 32'(count_o), 32'd1);
        chk("midrst_ovf", 32'(overflow_o), 32'd0);
        chk("midrst_tmo", 32'(timeout_o), 32'd0);
        do_pop();

        // Partial word followed by a long idle period.
        send_nib(4'hA); send_nib(4'hB); send_nib(4'hC);
        pulses = 0;
        for (int c = 0; c < TMO + 10; c++) begin
            @(negedge clk);
            if (timeout_o) pulses++;
        end
`ifdef T07_ESP_RX_TIMEOUT_EN
        chk("tmo_pulses", 32'(pulses), 32'd1);
        send_word(32'h87654321, 1'b0);
        chk("tmo_data", data_o, 32'h87654321);
`else
        chk("tmo_pulses", 32'(pulses), 32'd0);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
        send_last(4'h5, 1'b0, 1'b0, 32'h0);
        chk("hold_data", data_o, 32'hABC12345);
`endif
        chk("tmo_count", 32'(count_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
